// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_high(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_if #(
  parameter int XLEN = 32
);
  import mdu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  mdu_op_t         op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] y;
  logic            zero;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, y, zero
  );

endinterface

// File: rtl/mdu_iterative.sv
// Radix-2 iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one 2*XLEN+1 accumulator, one iteration per clock.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);

  localparam int AW = 2 * XLEN + 1;
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     acc_q, acc_step;
  logic [XLEN-1:0]   opnd_q;
  mdu_op_t           op_q;
  logic              neg_q, neg_rem_q;
  logic [XLEN-1:0]   y_q;
  logic              zero_q;

  logic              accept, last;
  logic              a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, y_spec, y_fin;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;

  // ---------------- request decode ----------------
  assign a_neg   = is_signed_a(bus.op) & bus.a[XLEN-1];
  assign b_neg   = is_signed_b(bus.op) & bus.b[XLEN-1];
  assign a_mag   = a_neg ? -bus.a : bus.a;
  assign b_mag   = b_neg ? -bus.b : bus.b;
  assign b_zero  = (bus.b == '0);
  assign ovf     = is_signed_a(bus.op) & (bus.a == MIN_INT) & (bus.b == '1);
  assign special = is_div(bus.op) & (b_zero | ovf);

  // Special divides finish without iterating: exact RISC-V results.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    y_spec = '0;
    if (b_zero) y_spec = is_rem(bus.op) ? bus.a : '1;
    else        y_spec = is_rem(bus.op) ? '0    : MIN_INT;
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.kill) begin
          accept  = 1'b1;
          state_d = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        last = (cnt_q == CNT_W'(1));
        if (bus.kill)  state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.kill || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- one iteration ----------------
  // Multiply: acc = {product_hi, multiplier}; add multiplicand on the LSB, shift right.
  // Divide:   acc = {remainder, quotient};   shift left, trial-subtract the divisor.
  always_comb begin
    sum      = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    diff     = {1'b0, acc_q[AW-2:XLEN-1]} - {2'b00, opnd_q};
    acc_step = {1'b0, sum, acc_q[XLEN-1:1]};
    if (is_div(op_q)) begin
      if (!diff[XLEN+1]) acc_step = {diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
      else               acc_step = {acc_q[AW-2:0], 1'b0};
    end
  end

  // Result of the final iteration, sign-corrected, registered on the BUSY -> DONE edge.
  always_comb begin
    prod  = acc_step[2*XLEN-1:0];
    y_fin = '0;
    if (is_div(op_q)) begin
      if (is_rem(op_q)) y_fin = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      else              y_fin = neg_q     ? -acc_step[XLEN-1:0]      : acc_step[XLEN-1:0];
    end else begin
      if (neg_q) prod = -acc_step[2*XLEN-1:0];
      y_fin = is_high(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  // ---------------- control state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (special) begin
          cnt_q  <= '0;
          y_q    <= y_spec;
          zero_q <= (y_spec == '0);
        end else begin
          cnt_q  <= CNT_LOAD;
        end
      end else if (state_q == BUSY) begin
        if (bus.kill) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (last) begin
            y_q    <= y_fin;
            zero_q <= (y_fin == '0);
          end
        end
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q     <= {{(XLEN+1){1'b0}}, (is_div(bus.op) ? a_mag : b_mag)};
      opnd_q    <= is_div(bus.op) ? b_mag : a_mag;
      op_q      <= bus.op;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (state_q == BUSY) begin
      acc_q <= acc_step;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed and model-checked stimulus for mdu_iterative (XLEN=32).
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mdu_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, pass the accept edge, then wait (bounded) for out_valid.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_y,
                        input logic exp_zero, input int exp_lat);
    int lat;
    issue(op, a, b, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_y"}, bus.y, exp_y);
    check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, exp_zero});
    release_result();
  endtask

  function automatic logic [31:0] ref_y(input mdu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        u;
    logic signed [65:0] sa, sb, p;
    logic signed [31:0] as, bs;
    logic               ovf;
    u   = {32'b0, a} * {32'b0, b};
    as  = a;
    bs  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    return u[31:0];
      OP_MULH:   begin sa = {{34{a[31]}}, a}; sb = {{34{b[31]}}, b}; p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin sa = {{34{a[31]}}, a}; sb = {34'b0, b};       p = sa * sb; return p[63:32]; end
      OP_MULHU:  return u[63:32];
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(as / bs);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(as % bs);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    bus.in_valid = 1'b0; bus.op = OP_MUL; bus.a = '0; bus.b = '0;
    bus.kill = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_y", bus.y, 32'h0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Multiply forms
    run_op("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);

    // Divide forms
    run_op("div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("rem",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("divu", OP_DIVU, 32'd100,       32'd7, 32'd14,        1'b0, 33);

    // Special divides
    run_op("divu_by0", OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1);
    run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         1'b0, 1);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 1);

    // Back-pressure in DONE
    issue(OP_MUL, 32'd3, 32'd5, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_y", bus.y, 32'd15);
      check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    release_result();

    // Kill in the 10th BUSY cycle
    bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("kill_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("kill_y_held", bus.y, 32'd15);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("kill_no_valid", seen, 0);
    run_op("after_kill", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0, 33);

    // Reset in the middle of a divide
    bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_y", bus.y, 32'h0);
    check("midrst_zero", {31'b0, bus.zero}, 32'd1);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Random ops against the reference model, with random back-pressure and kills
    for (int n = 0; n < 150; n++) begin
      mdu_op_t     op;
      logic [31:0] a, b, exp_y;
      int          exp_lat;
      op = mdu_op_t'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        default: ;
      endcase
      exp_y   = ref_y(op, a, b);
      exp_lat = (is_div(op) && (b == 0 || (is_signed_a(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      if ($urandom_range(0, 7) == 0) begin
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = $urandom_range(0, 36); i > 0; i--) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check("rnd_kill_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rnd_kill_in_ready", {31'b0, bus.in_ready}, 32'd1);
      end else begin
        issue(op, a, b, lat);
        check("rnd_lat", lat, exp_lat);
        check("rnd_y", bus.y, exp_y);
        check("rnd_zero", {31'b0, bus.zero}, {31'b0, (exp_y == 32'h0)});
        for (int i = $urandom_range(0, 3); i > 0; i--) tick();
        check("rnd_y_stable", bus.y, exp_y);
        release_result();
        check("rnd_in_ready", {31'b0, bus.in_ready}, 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
